// File: rtl/keys_pkg.sv
// Shared definitions for the key generator sequencer.
//   KEY_W     : key / seed / LFSR width
//   state_e   : sequencer FSM states
//   ZERO_SEED : all-zero value, the LFSR lock-up state
//   max_u     : constant helper for counter sizing
package keys_pkg;

    localparam int unsigned KEY_W = 128;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        WARMUP = 3'd2,
        READY  = 3'd3,
        STEP   = 3'd4
    } state_e;

    localparam logic [KEY_W-1:0] ZERO_SEED = '0;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
//   i_clk, i_rst_n : clock, async active-low reset (pointer returns to 0)
//   i_req          : per-requester request levels
//   i_advance      : the current winner was granted; move priority past it
//   o_grant_c      : combinational one-hot winner (zero when no request)
//   o_ptr          : registered index of the highest-priority requester
module key_rr_arbiter
    import keys_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_advance,
    output logic [N_REQ-1:0] o_grant_c,
    output logic [PTR_W-1:0] o_ptr
);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_win_idx;
    logic             w_found;
    int unsigned      w_scan;

    // Scan requesters starting at the pointer, wrapping once; first hit wins.
    always_comb begin
        o_grant_c = '0;
        w_win_idx = r_ptr;
        w_found   = 1'b0;
        w_scan    = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_scan = 32'(r_ptr) + k;
            if (w_scan >= N_REQ) begin
                w_scan = w_scan - N_REQ;
            end
            if (!w_found && i_req[PTR_W'(w_scan)]) begin
                w_found                   = 1'b1;
                w_win_idx                 = PTR_W'(w_scan);
                o_grant_c[PTR_W'(w_scan)] = 1'b1;
            end
        end
    end

    // Priority moves to the requester after the one just granted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_advance && w_found) begin
            r_ptr <= (w_win_idx == PTR_W'(N_REQ - 1)) ? '0 : w_win_idx + PTR_W'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/keys_generator_ctrl.sv
// Sequencer and arbiter in front of a 128-bit LFSR key generator: seeds it,
// runs a warm-up, then hands out keys round-robin, stepping the LFSR
// KEY_STRIDE times between keys. Sole driver of the LFSR control inputs.
//   in_clk, in_rst_n   : clock, async active-low reset
//   in_seed_valid/in_seed, out_seed_ready : seed handshake
//   out_seed_err       : 1-cycle pulse, zero seed offered and rejected
//   in_req / out_grant : request levels, one-hot grant pulse
//   out_key            : key for the granted requester (held otherwise)
//   out_reseed_req     : MAX_KEYS keys issued, grants blocked until reseed
//   out_lfsr_stop/out_lfsr_wr_seed/out_lfsr_seed : LFSR control
//   in_lfsr_value      : current LFSR state
module keys_generator_ctrl
    import keys_pkg::*;
#(
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned WARMUP_CYCLES = 128,
    parameter int unsigned KEY_STRIDE    = 128,
    parameter int unsigned MAX_KEYS      = 1024
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic             in_seed_valid,
    input  logic [KEY_W-1:0] in_seed,
    output logic             out_seed_ready,
    output logic             out_seed_err,
    input  logic [N_REQ-1:0] in_req,
    output logic [N_REQ-1:0] out_grant,
    output logic [KEY_W-1:0] out_key,
    output logic             out_reseed_req,
    output logic             out_lfsr_stop,
    output logic             out_lfsr_wr_seed,
    output logic [KEY_W-1:0] out_lfsr_seed,
    input  logic [KEY_W-1:0] in_lfsr_value
);

    localparam int unsigned CNT_W  = $clog2(max_u(WARMUP_CYCLES, KEY_STRIDE) + 1);
    localparam int unsigned KCNT_W = $clog2(MAX_KEYS + 1);
    localparam int unsigned PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e              r_state, w_state_next;
    logic [CNT_W-1:0]    r_cnt, w_cnt_next;
    logic [KCNT_W-1:0]   r_keys, w_keys_next;
    logic [KEY_W-1:0]    r_seed, w_seed_next;
    logic [KEY_W-1:0]    r_key, w_key_next;
    logic [N_REQ-1:0]    r_grant, w_grant_next;
    logic                r_stop, w_stop_next;
    logic                r_wr_seed, w_wr_seed_next;
    logic                r_seed_ready, w_seed_ready_next;
    logic                r_seed_err, w_seed_err_next;
    logic                r_reseed_req, w_reseed_req_next;
    logic                w_seed_acc, w_seed_load, w_advance;
    logic [N_REQ-1:0]    w_arb_grant;
    logic [PTR_W-1:0]    w_rr_ptr, w_ptr_prev;

    assign w_seed_acc  = in_seed_valid && r_seed_ready;
    assign w_seed_load = w_seed_acc && (in_seed != ZERO_SEED);

    key_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .i_clk     (in_clk),
        .i_rst_n   (in_rst_n),
        .i_req     (in_req),
        .i_advance (w_advance),
        .o_grant_c (w_arb_grant),
        .o_ptr     (w_rr_ptr)
    );

    // FSM state register.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, counters, grant decision and next values of all outputs.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_keys_next     = r_keys;
        w_seed_next     = r_seed;
        w_key_next      = r_key;
        w_grant_next    = '0;
        w_advance       = 1'b0;
        w_seed_err_next = w_seed_acc && (in_seed == ZERO_SEED);

        if (w_seed_load) begin
            // A valid seed aborts whatever is running, grants included.
            w_state_next = LOAD;
            w_seed_next  = in_seed;
            w_keys_next  = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_state_next = IDLE;
                end
                LOAD: begin
                    w_state_next = WARMUP;
                    w_cnt_next   = CNT_W'(WARMUP_CYCLES - 1);
                end
                WARMUP: begin
                    if (r_cnt == '0) begin
                        w_state_next = READY;
                    end else begin
                        w_cnt_next = r_cnt - CNT_W'(1);
                    end
                end
                READY: begin
                    if ((|in_req) && (r_keys < KCNT_W'(MAX_KEYS))) begin
                        w_grant_next = w_arb_grant;
                        w_key_next   = in_lfsr_value;
                        w_keys_next  = r_keys + KCNT_W'(1);
                        w_advance    = 1'b1;
                        w_state_next = STEP;
                        w_cnt_next   = CNT_W'(KEY_STRIDE - 1);
                    end
                end
                STEP: begin
                    if (r_cnt == '0) begin
                        w_state_next = READY;
                    end else begin
                        w_cnt_next = r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end

        // Outputs follow the state being entered so they line up with it.
        w_stop_next       = !((w_state_next == WARMUP) || (w_state_next == STEP));
        w_wr_seed_next    = (w_state_next == LOAD);
        w_seed_ready_next = (w_state_next != LOAD);
        w_reseed_req_next = (w_keys_next == KCNT_W'(MAX_KEYS));
    end

    // Counters, captured seed/key and registered outputs.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_cnt        <= '0;
            r_keys       <= '0;
            r_seed       <= '0;
            r_key        <= '0;
            r_grant      <= '0;
            r_stop       <= 1'b1;
            r_wr_seed    <= 1'b0;
            r_seed_ready <= 1'b0;
            r_seed_err   <= 1'b0;
            r_reseed_req <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_next;
            r_keys       <= w_keys_next;
            r_seed       <= w_seed_next;
            r_key        <= w_key_next;
            r_grant      <= w_grant_next;
            r_stop       <= w_stop_next;
            r_wr_seed    <= w_wr_seed_next;
            r_seed_ready <= w_seed_ready_next;
            r_seed_err   <= w_seed_err_next;
            r_reseed_req <= w_reseed_req_next;
        end
    end

    assign out_seed_ready   = r_seed_ready;
    assign out_seed_err     = r_seed_err;
    assign out_grant        = r_grant;
    assign out_key          = r_key;
    assign out_reseed_req   = r_reseed_req;
    assign out_lfsr_stop    = r_stop;
    assign out_lfsr_wr_seed = r_wr_seed;
    assign out_lfsr_seed    = r_seed;

    // The pointer has already moved past the requester shown on out_grant.
    assign w_ptr_prev = (w_rr_ptr == '0) ? PTR_W'(N_REQ - 1) : w_rr_ptr - PTR_W'(1);

    a_grant_onehot_ptr: assert property (@(posedge in_clk) disable iff (!in_rst_n)
        (|r_grant) |-> ($onehot(r_grant) && r_grant[w_ptr_prev]));

endmodule

// File: tb/tb_keys_generator_ctrl.sv
// Directed bench for keys_generator_ctrl with a behavioural 128-bit LFSR
// standing in for keys_generator. WARMUP_CYCLES=4, KEY_STRIDE=3, MAX_KEYS=2.
module tb_keys_generator_ctrl;
    import keys_pkg::*;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned WARM   = 4;
    localparam int unsigned STRIDE = 3;
    localparam int unsigned MAXK   = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             seed_valid;
    logic [KEY_W-1:0] seed;
    logic             seed_ready, seed_err;
    logic [N_REQ-1:0] req, grant;
    logic [KEY_W-1:0] key;
    logic             reseed_req, stop, wr_seed;
    logic [KEY_W-1:0] lfsr_seed;
    logic [KEY_W-1:0] lfsr = '0;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [KEY_W-1:0] S1 = {8{16'h7894}};
    localparam logic [KEY_W-1:0] S2 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    localparam logic [KEY_W-1:0] S3 = 128'h1;
    localparam logic [KEY_W-1:0] S4 = 128'hdead_beef_0000_0000_0000_0000_cafe_f00d;
    localparam logic [KEY_W-1:0] S5 = 128'h8000_0000_0000_0000_0000_0000_0000_0001;

    always #5 clk = ~clk;

    function automatic logic [KEY_W-1:0] lfsr_next(input logic [KEY_W-1:0] x);
        return {x[126:0], x[127] ^ x[125] ^ x[100] ^ x[98]};
    endfunction

    function automatic logic [KEY_W-1:0] lfsr_adv(input logic [KEY_W-1:0] x, input int n);
        logic [KEY_W-1:0] v;
        v = x;
        for (int i = 0; i < n; i++) v = lfsr_next(v);
        return v;
    endfunction

    // Stand-in keys_generator: no reset, as in the real block.
    always @(posedge clk) begin
        if (wr_seed)    lfsr <= lfsr_seed;
        else if (!stop) lfsr <= lfsr_next(lfsr);
    end

    keys_generator_ctrl #(
        .N_REQ(N_REQ), .WARMUP_CYCLES(WARM), .KEY_STRIDE(STRIDE), .MAX_KEYS(MAXK)
    ) dut (
        .in_clk           (clk),
        .in_rst_n         (rst_n),
        .in_seed_valid    (seed_valid),
        .in_seed          (seed),
        .out_seed_ready   (seed_ready),
        .out_seed_err     (seed_err),
        .in_req           (req),
        .out_grant        (grant),
        .out_key          (key),
        .out_reseed_req   (reseed_req),
        .out_lfsr_stop    (stop),
        .out_lfsr_wr_seed (wr_seed),
        .out_lfsr_seed    (lfsr_seed),
        .in_lfsr_value    (lfsr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; seed_valid = 1'b0; seed = '0; req = '0;
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (stop !== 1'b1) $display("FAIL reset_stop: got %b want 1", stop); else n_pass++;
        n_checks++; if (key !== '0) $display("FAIL reset_key: got %h want 0", key); else n_pass++;
        n_checks++;
        if ({grant, seed_ready, seed_err, reseed_req, wr_seed} !== '0 || lfsr_seed !== '0)
            $display("FAIL reset_outs: grant=%b rdy=%b err=%b rsq=%b wr=%b seed=%h want all 0",
                     grant, seed_ready, seed_err, reseed_req, wr_seed, lfsr_seed);
        else n_pass++;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (seed_ready !== 1'b1) $display("FAIL idle_ready: got %b want 1", seed_ready); else n_pass++;
    endtask

    task automatic test_seed_warmup();
        int bad;
        seed = S1; seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        n_checks++;
        if (wr_seed !== 1'b1 || lfsr_seed !== S1 || seed_ready !== 1'b0 || stop !== 1'b1)
            $display("FAIL load_outs: wr=%b seed=%h rdy=%b stop=%b want 1 %h 0 1", wr_seed, lfsr_seed, seed_ready, stop, S1);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < int'(WARM); i++) begin
            tick();
            if (stop !== 1'b0 || wr_seed !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL warmup_stop: %0d bad cycles want 0", bad); else n_pass++;
        tick();
        n_checks++; if (stop !== 1'b1) $display("FAIL ready_stop: got %b want 1", stop); else n_pass++;
        n_checks++;
        if (lfsr !== lfsr_adv(S1, 4)) $display("FAIL warmup_lfsr: got %h want %h", lfsr, lfsr_adv(S1, 4));
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [KEY_W-1:0] k0;
        int bad;
        req = 4'b1111;
        tick();
        n_checks++;
        if (grant !== 4'b0001 || key !== lfsr_adv(S1, 4))
            $display("FAIL grant0: grant=%b key=%h want 0001 %h", grant, key, lfsr_adv(S1, 4));
        else n_pass++;
        k0 = key;
        bad = 0;
        repeat (3) begin tick(); if (grant !== '0) bad++; end
        n_checks++; if (bad != 0 || stop !== 1'b1) $display("FAIL spacing: bad=%0d stop=%b want 0 1", bad, stop); else n_pass++;
        tick();
        n_checks++;
        if (grant !== 4'b0010 || key !== lfsr_adv(S1, 7))
            $display("FAIL grant1: grant=%b key=%h want 0010 %h", grant, key, lfsr_adv(S1, 7));
        else n_pass++;
        n_checks++; if (key === k0) $display("FAIL keys_differ: both %h", key); else n_pass++;
        n_checks++; if (reseed_req !== 1'b1) $display("FAIL reseed_set: got %b want 1", reseed_req); else n_pass++;
        bad = 0;
        repeat (8) begin tick(); if (grant !== '0 || reseed_req !== 1'b1) bad++; end
        n_checks++; if (bad != 0) $display("FAIL reseed_block: %0d bad cycles want 0", bad); else n_pass++;
        n_checks++;
        if (lfsr !== lfsr_adv(S1, 10)) $display("FAIL held_lfsr: got %h want %h", lfsr, lfsr_adv(S1, 10));
        else n_pass++;
        seed = S2; seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        n_checks++;
        if (wr_seed !== 1'b1 || grant !== '0 || reseed_req !== 1'b0)
            $display("FAIL reseed_clear: wr=%b grant=%b rsq=%b want 1 0000 0", wr_seed, grant, reseed_req);
        else n_pass++;
        repeat (5) tick();
        tick();
        n_checks++;
        if (grant !== 4'b0100 || key !== lfsr_adv(S2, 4))
            $display("FAIL grant2: grant=%b key=%h want 0100 %h", grant, key, lfsr_adv(S2, 4));
        else n_pass++;
        repeat (3) tick();
        tick();
        n_checks++;
        if (grant !== 4'b1000 || key !== lfsr_adv(S2, 7))
            $display("FAIL grant3: grant=%b key=%h want 1000 %h", grant, key, lfsr_adv(S2, 7));
        else n_pass++;
        req = '0;
    endtask

    task automatic test_reseed_abort();
        int bad;
        repeat (3) tick();
        seed = S3; seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        n_checks++; if (wr_seed !== 1'b1) $display("FAIL ready_reseed: wr=%b want 1", wr_seed); else n_pass++;
        tick(); tick();
        seed = S4; seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        n_checks++;
        if (wr_seed !== 1'b1 || stop !== 1'b1 || lfsr_seed !== S4)
            $display("FAIL warmup_abort: wr=%b stop=%b seed=%h want 1 1 %h", wr_seed, stop, lfsr_seed, S4);
        else n_pass++;
        bad = 0;
        repeat (4) begin tick(); if (stop !== 1'b0) bad++; end
        tick();
        n_checks++;
        if (bad != 0 || stop !== 1'b1 || lfsr !== lfsr_adv(S4, 4))
            $display("FAIL warmup_restart: bad=%0d stop=%b lfsr=%h want 0 1 %h", bad, stop, lfsr, lfsr_adv(S4, 4));
        else n_pass++;
        req = 4'b0001; seed = S5; seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        n_checks++;
        if (grant !== '0 || wr_seed !== 1'b1)
            $display("FAIL seed_priority: grant=%b wr=%b want 0000 1", grant, wr_seed);
        else n_pass++;
        repeat (5) tick();
        tick();
        n_checks++;
        if (grant !== 4'b0001 || key !== lfsr_adv(S5, 4))
            $display("FAIL grant_after_abort: grant=%b key=%h want 0001 %h", grant, key, lfsr_adv(S5, 4));
        else n_pass++;
    endtask

    task automatic test_reset_mid_step();
        int bad;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (stop !== 1'b1 || grant !== '0 || key !== '0 || wr_seed !== 1'b0 || reseed_req !== 1'b0)
            $display("FAIL async_reset: stop=%b grant=%b key=%h wr=%b rsq=%b want 1 0 0 0 0",
                     stop, grant, key, wr_seed, reseed_req);
        else n_pass++;
        tick(); tick();
        rst_n = 1'b1;
        req = 4'b1111;
        bad = 0;
        repeat (10) begin tick(); if (grant !== '0 || stop !== 1'b1) bad++; end
        n_checks++; if (bad != 0) $display("FAIL no_grant_unseeded: %0d bad cycles want 0", bad); else n_pass++;
        req = '0;
    endtask

    task automatic test_zero_seed();
        int bad;
        seed = ZERO_SEED; seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        n_checks++;
        if (seed_err !== 1'b1 || wr_seed !== 1'b0 || seed_ready !== 1'b1)
            $display("FAIL zero_seed_err: err=%b wr=%b rdy=%b want 1 0 1", seed_err, wr_seed, seed_ready);
        else n_pass++;
        bad = 0;
        repeat (6) begin tick(); if (seed_err !== 1'b0 || wr_seed !== 1'b0 || stop !== 1'b1) bad++; end
        n_checks++; if (bad != 0) $display("FAIL zero_seed_idle: %0d bad cycles want 0", bad); else n_pass++;
        seed = S1; seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        n_checks++;
        if (wr_seed !== 1'b1 || seed_err !== 1'b0)
            $display("FAIL idle_after_zero: wr=%b err=%b want 1 0", wr_seed, seed_err);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_seed_warmup();
        test_round_robin();
        test_reseed_abort();
        test_reset_mid_step();
        test_zero_seed();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
